// File: rtl/subinst_arb_pkg.sv
// Shared definitions for the root-level sub-instance arbiters.
package subinst_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Default configuration for a five-instance root.
  localparam int N_REQ_DEF    = 5;
  localparam int MAX_HOLD_DEF = 16;
  localparam int CNT_W_DEF    = 16;

endpackage : subinst_arb_pkg

// File: rtl/subinst_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Scans i_ptr, i_ptr+1, ... (mod N_REQ) and returns the first requester found
// as a one-hot vector plus its index. i_ptr is always kept below N_REQ by the user.
module rr_pick #(
  parameter int N_REQ = 5,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int              w_cand_int;
  logic [ID_W-1:0] w_cand;

  // First set request at or after the pointer, wrapping once around.
  always_comb begin
    o_pick     = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_cand_int = 0;
    w_cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand_int = int'(i_ptr) + k;
      if (w_cand_int >= N_REQ) w_cand_int = w_cand_int - N_REQ;
      w_cand = ID_W'(w_cand_int);
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_idx          = w_cand;
        o_pick[w_cand] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/subinst_rr_arbiter.sv
// subinst_rr_arbiter: round-robin owner arbitration for the generated
// sub-instances. One owner at a time; the owner keeps the grant until it
// pulses done, drops its request, or exhausts MAX_HOLD cycles.
// Handshake: a requester holds req high until it sees its gnt bit; the grant
// stays registered until the release cycle, after which gnt is low for at
// least one cycle before the next owner is granted.
module subinst_rr_arbiter
  import subinst_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          done,
  output logic [N_REQ-1:0]          gnt,
  output logic                      gnt_valid,
  output logic [$clog2(N_REQ)-1:0]  gnt_id,
  output logic                      timeout,
  output logic [CNT_W-1:0]          grant_cnt,
  output logic [CNT_W-1:0]          timeout_cnt,
  output arb_state_e                o_dbg_state
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  arb_state_e        r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_gnt_valid;
  logic [ID_W-1:0]   r_gnt_id;
  logic [ID_W-1:0]   r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_grant_cnt;
  logic [CNT_W-1:0]  r_timeout_cnt;

  logic [N_REQ-1:0]  w_pick;
  logic [ID_W-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_release;
  logic              w_expire;
  logic [ID_W-1:0]   w_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Release and expiry conditions look only at the owner's bits; r_gnt is
  // one-hot, so masking with it selects the owner without indexing.
  always_comb begin
    w_release  = |(done & r_gnt) || !(|(req & r_gnt));
    w_expire   = (r_hold == HOLD_W'(MAX_HOLD - 1));
    w_ptr_next = (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
  end

  // Grant FSM: arbitrate in IDLE, hold and release in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_gnt       <= w_pick;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_pick_idx;
            r_hold      <= '0;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_hold <= r_hold + HOLD_W'(1);
          if (w_release || w_expire) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_IDLE;
            // A real release in the expiry cycle wins over the timeout.
            r_timeout   <= !w_release;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating statistics: grants issued and forced releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt   <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_any && r_grant_cnt != '1)
        r_grant_cnt <= r_grant_cnt + CNT_W'(1);
      if (r_state == ST_GRANT && w_expire && !w_release && r_timeout_cnt != '1)
        r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
    end
  end

  assign gnt         = r_gnt;
  assign gnt_valid   = r_gnt_valid;
  assign gnt_id      = r_gnt_id;
  assign timeout     = r_timeout;
  assign grant_cnt   = r_grant_cnt;
  assign timeout_cnt = r_timeout_cnt;
  assign o_dbg_state = r_state;

endmodule : subinst_rr_arbiter
